// File: rtl/apu_seq_pkg.sv
// Shared types for the APU register-write sequencer: register selects,
// program entries, the reset-time noise program and the FSM states.
package apu_seq_pkg;

   typedef enum logic [1:0] {
      SEL_4015 = 2'd0,
      SEL_400C = 2'd1,
      SEL_400E = 2'd2,
      SEL_400F = 2'd3
   } reg_sel_e;

   typedef struct packed {
      reg_sel_e   sel;
      logic [7:0] data;
   } prog_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_e;

   // Noise setup: LC enable, envelope 6, period 7, length index 11111.
   localparam prog_entry_t DEF_ENTRY_0 = '{sel: SEL_4015, data: 8'h08};
   localparam prog_entry_t DEF_ENTRY_1 = '{sel: SEL_400C, data: 8'h06};
   localparam prog_entry_t DEF_ENTRY_2 = '{sel: SEL_400E, data: 8'h07};
   localparam prog_entry_t DEF_ENTRY_3 = '{sel: SEL_400F, data: 8'hF8};
   localparam prog_entry_t BLANK_ENTRY = '{sel: SEL_4015, data: 8'h00};

   function automatic prog_entry_t default_entry(input int i);
      case (i)
         32'd0:   return DEF_ENTRY_0;
         32'd1:   return DEF_ENTRY_1;
         32'd2:   return DEF_ENTRY_2;
         32'd3:   return DEF_ENTRY_3;
         default: return BLANK_ENTRY;
      endcase
   endfunction

   function automatic logic [3:0] sel_onehot(input reg_sel_e s);
      case (s)
         SEL_4015: return 4'b0001;
         SEL_400C: return 4'b0010;
         SEL_400E: return 4'b0100;
         SEL_400F: return 4'b1000;
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/apu_seq_prog_ram.sv
// DEPTH-entry program store: synchronous write, combinational read,
// reset reloads the default noise program.
module apu_seq_prog_ram
   import apu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  prog_entry_t   wentry_i,
   input  logic [AW-1:0] raddr_i,
   output prog_entry_t   rentry_o
);

   prog_entry_t mem_q [DEPTH];

   // Reset to the default program; out-of-range write indices are dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= default_entry(i);
         end
      end else if (we_i && (int'(waddr_i) < DEPTH)) begin
         mem_q[waddr_i] <= wentry_i;
      end
   end

   assign rentry_o = mem_q[raddr_i];

endmodule

// File: rtl/apu_reg_sequencer.sv
// Replays a short (register, data) program onto the APU register strobes
// and DataBus with fixed strobe/gap widths, then pulses done.
module apu_reg_sequencer
   import apu_seq_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int STROBE_CYCLES = 6,
   parameter int GAP_CYCLES    = 6
) (
   input  logic                                        CLK,
   input  logic                                        RES,
   input  logic                                        PHI1,
   input  logic                                        start,
   input  logic [$clog2(DEPTH+1)-1:0]                  len,
   input  logic                                        prog_we,
   input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] prog_addr,
   input  logic [1:0]                                  prog_sel,
   input  logic [7:0]                                  prog_data,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        W4015,
   output logic                                        W400C,
   output logic                                        W400E,
   output logic                                        W400F,
   inout  wire  [7:0]                                  DataBus
);

   localparam int LW   = $clog2(DEPTH + 1);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MAXC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   seq_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] elen_q, elen_d;
   logic [3:0]    strobe_q, strobe_d;
   logic [7:0]    data_q, data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [LW-1:0] eff_len_s;
   logic          last_idx_s;
   logic          prog_we_s;
   prog_entry_t   wentry_s;
   prog_entry_t   rentry_s;

   assign eff_len_s  = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
   assign last_idx_s = (LW'(idx_q) == (elen_q - LW'(1)));
   assign prog_we_s  = prog_we && (state_q == ST_IDLE);
   assign wentry_s   = '{sel: reg_sel_e'(prog_sel), data: prog_data};

   apu_seq_prog_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_ram (
      .clk_i    (CLK),
      .rst_i    (RES),
      .we_i     (prog_we_s),
      .waddr_i  (prog_addr),
      .wentry_i (wentry_s),
      .raddr_i  (idx_d),
      .rentry_o (rentry_s)
   );

   // Sequencing FSM; outputs are decoded from the next state so they register in step with it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      elen_d  = elen_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               elen_d  = eff_len_s;
               idx_d   = {AW{1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = (eff_len_s != {LW{1'b0}}) ? ST_STROBE : ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STROBE: begin
            if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
               state_d = ST_GAP;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               cnt_d = {CW{1'b0}};
               if (last_idx_s) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = ST_STROBE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      strobe_d = (state_d == ST_STROBE) ? sel_onehot(rentry_s.sel) : 4'b0000;
      data_d   = (state_d == ST_STROBE) ? rentry_s.data : 8'h00;
      busy_d   = (state_d == ST_STROBE) || (state_d == ST_GAP);
      done_d   = (state_d == ST_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q  <= ST_IDLE;
         idx_q    <= {AW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         elen_q   <= {LW{1'b0}};
         strobe_q <= 4'b0000;
         data_q   <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         elen_q   <= elen_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign W4015 = strobe_q[0];
   assign W400C = strobe_q[1];
   assign W400E = strobe_q[2];
   assign W400F = strobe_q[3];

   // The bus is only ever driven during PHI1 low while a strobe is active.
   assign DataBus = (!PHI1 && (strobe_q != 4'b0000)) ? data_q : 8'hzz;

endmodule

// File: tb/tb_apu_reg_sequencer.sv
// Randomized self-checking bench for apu_reg_sequencer; expected traces come
// from a per-cycle timeline model of the program (entry = n / (S+G)).
module tb_apu_reg_sequencer;

   localparam int DEPTH = 4;
   localparam int S     = 6;
   localparam int G     = 6;
   localparam int PER   = S + G;
   localparam int NCAP  = DEPTH * PER + 4;

   logic       CLK       = 1'b0;
   logic       RES       = 1'b0;
   logic       PHI1      = 1'b1;
   logic       start     = 1'b0;
   logic [2:0] len       = 3'd0;
   logic       prog_we   = 1'b0;
   logic [1:0] prog_addr = 2'd0;
   logic [1:0] prog_sel  = 2'd0;
   logic [7:0] prog_data = 8'h00;
   logic       busy, done, W4015, W400C, W400E, W400F;
   // Undriven bus reads back as FF; random program data never uses FF.
   tri1  [7:0] DataBus;

   int checks   = 0;
   int failures = 0;

   int          m_sel  [DEPTH];
   logic [7:0]  m_data [DEPTH];
   logic [13:0] obs     [NCAP];
   bit          phi_log [NCAP];

   apu_reg_sequencer #(
      .DEPTH         (DEPTH),
      .STROBE_CYCLES (S),
      .GAP_CYCLES    (G)
   ) dut (
      .CLK       (CLK),
      .RES       (RES),
      .PHI1      (PHI1),
      .start     (start),
      .len       (len),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_sel  (prog_sel),
      .prog_data (prog_data),
      .busy      (busy),
      .done      (done),
      .W4015     (W4015),
      .W400C     (W400C),
      .W400E     (W400E),
      .W400F     (W400F),
      .DataBus   (DataBus)
   );

   always #5 CLK = ~CLK;

   function automatic void model_defaults();
      m_sel  = '{0, 1, 2, 3};
      m_data = '{8'h08, 8'h06, 8'h07, 8'hF8};
   endfunction

   // {busy, done, W400F, W400E, W400C, W4015, DataBus} n cycles after start is taken.
   function automatic logic [13:0] expect_at(input int n, input int eff, input bit phi);
      logic [3:0] st;
      logic [7:0] bus;
      int         e;
      e  = n / PER;
      st = 4'b0000;
      if ((n < eff * PER) && ((n % PER) < S)) st = 4'b0001 << m_sel[e];
      bus = ((st != 4'b0000) && !phi) ? m_data[e] : 8'hFF;
      return {(n < eff * PER), (n == eff * PER), st, bus};
   endfunction

   function automatic logic [13:0] sample_now();
      return {busy, done, W400F, W400E, W400C, W4015, DataBus};
   endfunction

   task automatic prog_write(input int a, input int sel, input logic [7:0] d);
      @(negedge CLK);
      prog_we   = 1'b1;
      prog_addr = 2'(a);
      prog_sel  = 2'(sel);
      prog_data = d;
      @(negedge CLK);
      prog_we   = 1'b0;
      m_sel[a]  = sel;
      m_data[a] = d;
   endtask

   // Issue start, record NCAP cycles; start held for hold_n cycles, junk writes for poke_n.
   task automatic capture(input int ln, input int hold_n, input int poke_n);
      @(negedge CLK);
      start = 1'b1;
      len   = 3'(ln);
      for (int n = 0; n < NCAP; n++) begin
         @(negedge CLK);
         PHI1 = 1'($urandom_range(0, 1));
         #1;
         phi_log[n] = PHI1;
         obs[n]     = sample_now();
         start      = (n < hold_n);
         prog_we    = (n < poke_n);
         prog_addr  = 2'($urandom_range(0, 3));
         prog_sel   = 2'($urandom_range(0, 3));
         prog_data  = 8'($urandom_range(0, 255));
      end
      start   = 1'b0;
      prog_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] s;
      RES = 1'b1;
      repeat (2) @(negedge CLK);
      RES  = 1'b0;
      PHI1 = 1'b0;
      #1;
      s = sample_now();
      model_defaults();
      checks++; if (s[13] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", s[13]); end
      checks++; if (s[12] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", s[12]); end
      checks++; if (s[11:8] !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", s[11:8]); end
      checks++; if (s[7:0] !== 8'hFF) begin failures++; $display("FAIL reset_bus got=%h exp=undriven(FF)", s[7:0]); end
   endtask

   task automatic test_default_run();
      logic [13:0] e;
      capture(4, 0, 0);
      for (int n = 0; n < NCAP; n++) begin
         e = expect_at(n, 4, phi_log[n]);
         checks++;
         if (obs[n] !== e) begin failures++; $display("FAIL default_run cyc=%0d got=%h exp=%h", n, obs[n], e); end
      end
   endtask

   task automatic test_len_edges();
      logic [13:0] e;
      for (int k = 0; k < 2; k++) begin
         capture((k == 0) ? 0 : 7, 0, 0);
         for (int n = 0; n < NCAP; n++) begin
            e = expect_at(n, (k == 0) ? 0 : DEPTH, phi_log[n]);
            checks++;
            if (obs[n] !== e) begin failures++; $display("FAIL len_edge k=%0d cyc=%0d got=%h exp=%h", k, n, obs[n], e); end
         end
      end
   endtask

   task automatic test_reprogram();
      logic [13:0] e;
      prog_write(1, 3, 8'h40);
      capture(2, 0, 0);
      for (int n = 0; n < NCAP; n++) begin
         e = expect_at(n, 2, phi_log[n]);
         checks++;
         if (obs[n] !== e) begin failures++; $display("FAIL reprogram cyc=%0d got=%h exp=%h", n, obs[n], e); end
      end
   endtask

   task automatic test_write_while_busy();
      logic [13:0] e;
      for (int k = 0; k < 2; k++) begin
         capture(4, 0, (k == 0) ? 4 * PER : 0);
         for (int n = 0; n < NCAP; n++) begin
            e = expect_at(n, 4, phi_log[n]);
            checks++;
            if (obs[n] !== e) begin failures++; $display("FAIL busy_write k=%0d cyc=%0d got=%h exp=%h", k, n, obs[n], e); end
         end
      end
   endtask

   task automatic test_restart_ignored();
      logic [13:0] e;
      int          ln;
      ln = $urandom_range(1, DEPTH);
      capture(ln, ln * PER, 0);
      for (int n = 0; n < NCAP; n++) begin
         e = expect_at(n, ln, phi_log[n]);
         checks++;
         if (obs[n] !== e) begin failures++; $display("FAIL restart cyc=%0d got=%h exp=%h", n, obs[n], e); end
      end
   endtask

   task automatic test_random_programs();
      logic [13:0] e;
      int          ln, eff;
      for (int it = 0; it < 4; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            prog_write(a, $urandom_range(0, 3), 8'($urandom_range(0, 254)));
         end
         ln  = $urandom_range(0, 7);
         eff = (ln > DEPTH) ? DEPTH : ln;
         capture(ln, 0, 0);
         for (int n = 0; n < NCAP; n++) begin
            e = expect_at(n, eff, phi_log[n]);
            checks++;
            if (obs[n] !== e) begin failures++; $display("FAIL random it=%0d len=%0d cyc=%0d got=%h exp=%h", it, ln, n, obs[n], e); end
         end
      end
   endtask

   task automatic test_reset_mid_strobe();
      logic [13:0] e, s;
      @(negedge CLK);
      start = 1'b1;
      len   = 3'd4;
      for (int n = 0; n <= PER + 1; n++) begin
         @(negedge CLK);
         start = 1'b0;
      end
      PHI1 = 1'b0;
      #1;
      s = sample_now();
      e = expect_at(PER + 1, 4, 1'b0);
      checks++; if (s !== e) begin failures++; $display("FAIL mid_strobe_pre got=%h exp=%h", s, e); end
      RES = 1'b1;
      @(negedge CLK);
      #1;
      s = sample_now();
      checks++; if (s !== {2'b00, 4'b0000, 8'hFF}) begin failures++; $display("FAIL mid_strobe_reset got=%h exp=%h", s, {2'b00, 4'b0000, 8'hFF}); end
      RES = 1'b0;
      model_defaults();
      capture(4, 0, 0);
      for (int n = 0; n < NCAP; n++) begin
         e = expect_at(n, 4, phi_log[n]);
         checks++;
         if (obs[n] !== e) begin failures++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", n, obs[n], e); end
      end
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_len_edges();
      test_reprogram();
      test_write_while_busy();
      test_restart_ignored();
      test_random_programs();
      test_reset_mid_strobe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
